// File: rtl/k6502_bus_trace_if.sv
// Bus-side and trace-stream signals of the k6502 bus trace monitor.
// master is the monitor's view; slave is the view of whatever drives the bus and drains the trace.
interface k6502_bus_trace_if;
    logic [15:0] a;
    logic [7:0]  d;
    logic        rw;
    logic        sync;
    logic        out_valid;
    logic        out_ready;
    logic [41:0] out_entry;

    modport master (
        input  a, d, rw, sync, out_ready,
        output out_valid, out_entry
    );

    modport slave (
        output a, d, rw, sync, out_ready,
        input  out_valid, out_entry
    );
endinterface

// File: rtl/k6502_bus_trace.sv
// Passive k6502 bus monitor: timestamps fetches and writes into a FIFO drained over valid/ready,
// and freezes capture once the CPU writes the stop address.
module k6502_bus_trace #(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [15:0] STOP_ADDR  = 16'hDEAD
) (
    input  logic                    clk,
    input  logic                    rst,
    k6502_bus_trace_if.master       bus,
    input  logic                    enable,
    output logic                    overflow,
    output logic [7:0]              drop_count,
    output logic                    done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STOPPED = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_r;
    logic [15:0]         stamp_r;
    logic [41:0]         mem_r [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_r;
    logic [DEPTH_LOG2:0] rd_ptr_r;
    logic                out_valid_r;
    logic [41:0]         out_entry_r;
    logic                overflow_r;
    logic [7:0]          drop_count_r;
    logic                done_r;

    logic                empty_s;
    logic                full_s;
    logic                capture_s;
    logic                stop_hit_s;
    logic                pop_s;
    logic                push_s;
    logic                drop_s;
    logic [1:0]          kind_s;
    logic [41:0]         event_entry_s;
    logic [DEPTH_LOG2:0] rd_next_s;
    logic [DEPTH_LOG2:0] wr_next_s;
    logic [41:0]         head_next_s;
    logic                valid_next_s;

    // Event classification, FIFO bookkeeping and next value of the registered head.
    always_comb begin
        empty_s    = (wr_ptr_r == rd_ptr_r);
        full_s     = (wr_ptr_r[DEPTH_LOG2] != rd_ptr_r[DEPTH_LOG2]) &&
                     (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0]);
        capture_s  = (state_r == RUN) && (bus.rw || bus.sync);
        stop_hit_s = (state_r == RUN) && bus.rw && (bus.a == STOP_ADDR);
        if (bus.rw) begin
            kind_s = 2'b01;
        end else begin
            kind_s = 2'b10;
        end
        event_entry_s = {kind_s, stamp_r, bus.a, bus.d};

        // The pop only counts when the head was already presented to the consumer.
        pop_s  = out_valid_r && bus.out_ready;
        push_s = capture_s && (!full_s || pop_s);
        drop_s = capture_s && full_s && !pop_s;

        rd_next_s = rd_ptr_r + {{DEPTH_LOG2{1'b0}}, pop_s};
        wr_next_s = wr_ptr_r + {{DEPTH_LOG2{1'b0}}, push_s};
        valid_next_s = (rd_next_s != wr_next_s);

        // A push into a FIFO that is empty after this cycle's pop bypasses memory.
        head_next_s = out_entry_r;
        if (push_s && (rd_next_s == wr_ptr_r)) begin
            head_next_s = event_entry_s;
        end else if (rd_next_s != wr_ptr_r) begin
            head_next_s = mem_r[rd_next_s[DEPTH_LOG2-1:0]];
        end else begin
            head_next_s = out_entry_r;
        end
    end

    // FIFO storage; contents are meaningful only between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= event_entry_s;
        end
    end

    // Trace state machine, stamp counter, pointers and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            stamp_r      <= 16'h0000;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            out_valid_r  <= 1'b0;
            out_entry_r  <= 42'd0;
            overflow_r   <= 1'b0;
            drop_count_r <= 8'h00;
            done_r       <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_next_s;
            rd_ptr_r    <= rd_next_s;
            out_valid_r <= valid_next_s;
            out_entry_r <= head_next_s;

            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_count_r != 8'hFF) begin
                    drop_count_r <= drop_count_r + 8'd1;
                end
            end

            if (state_r == RUN) begin
                stamp_r <= stamp_r + 16'd1;
            end

            case (state_r)
                IDLE: begin
                    if (enable) begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (stop_hit_s) begin
                        state_r <= STOPPED;
                    end else if (!enable) begin
                        state_r <= IDLE;
                    end
                end
                STOPPED: begin
                    if (empty_s) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    done_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_entry = out_entry_r;
    assign overflow      = overflow_r;
    assign drop_count    = drop_count_r;
    assign done          = done_r;

endmodule

// File: tb/tb_k6502_bus_trace.sv
// Directed bench for k6502_bus_trace: capture, ordering, overflow, stop/done, reset and stamp wrap.
module tb_k6502_bus_trace;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       overflow;
    logic [7:0] drop_count;
    logic       done;
    int         tests_run;
    int         tests_failed;

    k6502_bus_trace_if bus ();

    k6502_bus_trace #(.DEPTH_LOG2(4), .STOP_ADDR(16'hDEAD)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.master),
        .enable     (enable),
        .overflow   (overflow),
        .drop_count (drop_count),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [41:0] ent(input logic [1:0] k, input logic [15:0] s,
                                        input logic [15:0] ad, input logic [7:0] dd);
        return {k, s, ad, dd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.rw = 1'b0; bus.sync = 1'b0; bus.a = 16'h0000; bus.d = 8'h00;
    endtask

    task automatic bus_set(input logic w, input logic s, input logic [15:0] ad, input logic [7:0] dd);
        bus.rw = w; bus.sync = s; bus.a = ad; bus.d = dd;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        enable = 1'b0;
        bus.out_ready = 1'b0;
        bus_idle();

        // Reset state
        tick(); tick();
        check_eq("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        check_eq("rst_entry", {22'd0, bus.out_entry}, 64'd0);
        check_eq("rst_ovf",   {63'd0, overflow}, 64'd0);
        check_eq("rst_drops", {56'd0, drop_count}, 64'd0);
        check_eq("rst_done",  {63'd0, done}, 64'd0);
        rst = 1'b0;

        // 1: enable cycle captures nothing, first fetch at stamp 0
        enable = 1'b1;
        bus_set(1'b0, 1'b1, 16'h8000, 8'hA9);
        tick();
        check_eq("t1_no_cap_on_enable", {63'd0, bus.out_valid}, 64'd0);
        tick();
        bus_idle();
        check_eq("t1_valid", {63'd0, bus.out_valid}, 64'd1);
        check_eq("t1_entry", {22'd0, bus.out_entry}, {22'd0, ent(2'b10, 16'h0000, 16'h8000, 8'hA9)});
        bus.out_ready = 1'b1;
        tick();
        tick();

        // 2: two writes at stamps 3 and 4, consumer always ready
        bus_set(1'b1, 1'b0, 16'h0200, 8'h55);
        tick();
        check_eq("t2_first", {22'd0, bus.out_entry}, {22'd0, ent(2'b01, 16'd3, 16'h0200, 8'h55)});
        tick();
        bus_idle();
        check_eq("t2_second_valid", {63'd0, bus.out_valid}, 64'd1);
        check_eq("t2_second", {22'd0, bus.out_entry}, {22'd0, ent(2'b01, 16'd4, 16'h0200, 8'h55)});
        tick();
        check_eq("t2_drained", {63'd0, bus.out_valid}, 64'd0);

        // 3: 20 writes into a stalled 16-deep FIFO, then drain in order
        bus.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus_set(1'b1, 1'b0, 16'h0300 + 16'(i), 8'(i));
            tick();
        end
        bus_idle();
        check_eq("t3_ovf",   {63'd0, overflow}, 64'd1);
        check_eq("t3_drops", {56'd0, drop_count}, 64'd4);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq("t3_drain_valid", {63'd0, bus.out_valid}, 64'd1);
            check_eq("t3_drain_entry", {22'd0, bus.out_entry},
                     {22'd0, ent(2'b01, 16'd6 + 16'(i), 16'h0300 + 16'(i), 8'(i))});
            tick();
        end
        check_eq("t3_empty", {63'd0, bus.out_valid}, 64'd0);

        // 4: stop-address write, later fetches ignored, done after final pop
        bus_set(1'b1, 1'b0, 16'hDEAD, 8'h01);
        tick();
        bus_set(1'b0, 1'b1, 16'h9000, 8'hEA);
        check_eq("t4_stop_entry", {22'd0, bus.out_entry}, {22'd0, ent(2'b01, 16'd42, 16'hDEAD, 8'h01)});
        check_eq("t4_done_early", {63'd0, done}, 64'd0);
        tick();
        check_eq("t4_no_cap_stopped", {63'd0, bus.out_valid}, 64'd0);
        check_eq("t4_done_not_yet", {63'd0, done}, 64'd0);
        tick();
        check_eq("t4_done", {63'd0, done}, 64'd1);
        tick();
        check_eq("t4_done_hold", {63'd0, done}, 64'd1);
        check_eq("t4_still_empty", {63'd0, bus.out_valid}, 64'd0);
        check_eq("t4_ovf_sticky", {63'd0, overflow}, 64'd1);

        // 5: reset clears sticky state; asynchronous reset mid-drain
        rst = 1'b1;
        #1;
        check_eq("t5_drops_cleared", {56'd0, drop_count}, 64'd0);
        check_eq("t5_ovf_cleared", {63'd0, overflow}, 64'd0);
        check_eq("t5_done_cleared", {63'd0, done}, 64'd0);
        bus_idle();
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus_set(1'b1, 1'b0, 16'h0400 + 16'(i), 8'h10 + 8'(i));
            tick();
        end
        bus_idle();
        check_eq("t5_head0", {22'd0, bus.out_entry}, {22'd0, ent(2'b01, 16'd0, 16'h0400, 8'h10)});
        bus.out_ready = 1'b1;
        tick();
        check_eq("t5_head1", {22'd0, bus.out_entry}, {22'd0, ent(2'b01, 16'd1, 16'h0401, 8'h11)});
        rst = 1'b1;
        #1;
        check_eq("t5_async_valid", {63'd0, bus.out_valid}, 64'd0);
        check_eq("t5_async_entry", {22'd0, bus.out_entry}, 64'd0);
        tick();
        rst = 1'b0;
        bus_set(1'b0, 1'b1, 16'hA000, 8'h4C);
        tick();
        check_eq("t5_idle_after_rst", {63'd0, bus.out_valid}, 64'd0);
        tick();
        bus_idle();
        check_eq("t5_stamp_restart", {22'd0, bus.out_entry}, {22'd0, ent(2'b10, 16'd0, 16'hA000, 8'h4C)});

        // 6: stamp wraps to 0, then holds while disabled
        repeat (65535) tick();
        check_eq("t6_pre_wrap_empty", {63'd0, bus.out_valid}, 64'd0);
        bus_set(1'b0, 1'b1, 16'hB000, 8'h00);
        tick();
        bus_idle();
        check_eq("t6_wrap_entry", {22'd0, bus.out_entry}, {22'd0, ent(2'b10, 16'h0000, 16'hB000, 8'h00)});
        enable = 1'b0;
        tick();
        check_eq("t6_popped", {63'd0, bus.out_valid}, 64'd0);
        bus_set(1'b0, 1'b1, 16'hB000, 8'h00);
        repeat (9) tick();
        check_eq("t6_no_cap_idle", {63'd0, bus.out_valid}, 64'd0);
        enable = 1'b1;
        tick();
        check_eq("t6_no_cap_enable", {63'd0, bus.out_valid}, 64'd0);
        tick();
        bus_idle();
        check_eq("t6_stamp_held", {22'd0, bus.out_entry}, {22'd0, ent(2'b10, 16'h0002, 16'hB000, 8'h00)});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/k6502_bus_trace.md
Name: k6502_bus_trace

Overview:
- Passive bus monitor downstream of the k6502 core; watches a/d/rw/sync every clock.
- Records instruction fetches and data writes as timestamped entries in an internal FIFO.
- Host logic (bench writer, UART dumper) drains entries over a valid/ready port.
- Detects a write to a stop address, then freezes capture and signals done once drained.

Parameters:
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries
STOP_ADDR, 16'hDEAD, write address that ends the trace

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous reset, active-high
a  in  16  CPU address bus
d  in  8  CPU data bus (read or write data)
rw  in  1  1 = write cycle, 0 = read cycle (k6502 polarity)
sync  in  1  1 = opcode fetch cycle
enable  in  1  1 = capture permitted
out_valid  out  1  FIFO head entry valid
out_ready  in  1  consumer accepts head entry
out_entry  out  42  {kind[1:0], stamp[15:0], addr[15:0], data[7:0]}
overflow  out  1  sticky: at least one event dropped
drop_count  out  8  dropped events, saturates at 8'hFF
done  out  1  STOPPED and FIFO empty

Behaviour:
- Reset (async, rst=1): state IDLE, FIFO empty, out_valid=0, out_entry=0, overflow=0, drop_count=0, done=0, stamp=0.
- Event classification, sampled on each posedge clk:
  - rw=1 → kind 2'b01 (WRITE).
  - rw=0 and sync=1 → kind 2'b10 (FETCH).
  - Anything else → no event.
  - kind 2'b00 and 2'b11 are never produced.
- Stamp: 16-bit cycle counter.
  - Increments every clk in RUN, wraps 16'hFFFF→0.
  - Holds in IDLE/STOPPED/DONE.
  - An entry carries the stamp value before that cycle's increment.
- State machine:
  - IDLE: no capture. Go to RUN when enable=1.
  - RUN: capture events. Go to IDLE when enable=0 (stamp holds; FIFO contents kept).
  - RUN → STOPPED on a WRITE with a==STOP_ADDR. That write is itself captured (if space).
  - STOPPED: no capture, enable ignored. Go to DONE when FIFO empty.
  - DONE: terminal until rst. done=1 is asserted in DONE only.
- Enable timing: the enable=1 cycle that moves IDLE→RUN captures nothing. The first capture is on the next clock.
- FIFO:
  - Registered output; latency 1 clk from event sample to out_valid=1 if the FIFO was empty.
  - Pop when out_valid & out_ready.
  - out_entry is stable while out_valid=1 and out_ready=0.
- Full FIFO:
  - With no pop that cycle: event dropped, overflow←1, drop_count+1 (saturating at 8'hFF).
  - With a simultaneous pop: push accepted, no drop.
- Empty FIFO with simultaneous push and pop: the pop is ignored (out_valid was 0). The entry appears the next cycle.
- Pointers are DEPTH_LOG2+1 bits with wrap bit; full/empty are derived from them.
- A STOP_ADDR write dropped due to a full FIFO still causes RUN→STOPPED and counts as a drop.
- Mid-operation reset (rst=1 at any time): immediate return to reset values. FIFO contents are discarded and out_valid drops asynchronously.

Test Plan:
1. rst=1 for 2 clk, release, enable=1, sync=1 a=16'h8000 d=8'hA9 rw=0 for 1 clk → next clk out_valid=1, out_entry={2'b10,16'h0000,16'h8000,8'hA9}.
2. Writes rw=1 a=16'h0200 d=8'h55 on consecutive stamps 3,4 with out_ready=1 → two WRITE entries in order, stamps 3 then 4, addr 16'h0200, data 8'h55.
3. out_ready=0, DEPTH_LOG2=4, 20 write events → 16 entries held, overflow=1, drop_count=4. Then out_ready=1 → 16 entries drain in order, out_valid=0 afterward.
4. Write a=16'hDEAD d=8'h01 in RUN, then further fetches → DEAD entry is last captured, later fetches ignored, done=1 one clk after final pop.
5. rst pulsed mid-drain with 5 entries queued → out_valid=0, drop_count=0, state IDLE within the same cycle; after release and enable, stamp restarts at 0.
6. Stamp wrap: run 65536 clk idle-bus, then fetch → entry stamp 16'h0000. Toggle enable to 0 for 10 clk → stamp holds.
